// File: rtl/input_debouncer.sv
// Debounces one raw input into a clean registered level using a settle-counter FSM.
// Define INPUT_DEBOUNCER_SYNC_EN to insert a two-flop synchronizer ahead of the FSM.
module input_debouncer #(
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic reset_high,
    input  logic raw,
    output logic level,
    output logic settling,
    output logic glitch
);

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    logic sampled;

`ifdef INPUT_DEBOUNCER_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or posedge reset_high) begin
        if (reset_high) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign sampled = sync2_q;
`else
    assign sampled = raw;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            level_q, level_d;
    logic            glitch_q, glitch_d;

    // A one-bit input can only ever disagree in one direction, so SETTLING never restarts.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        level_d  = level_q;
        glitch_d = 1'b0;
        case (state_q)
            ST_STABLE: begin
                count_d = '0;
                if (sampled != level_q) begin
                    if (SETTLE_CYCLES == 1) begin
                        level_d = sampled;
                    end else begin
                        count_d = CW'(1);
                        state_d = ST_SETTLING;
                    end
                end
            end
            ST_SETTLING: begin
                if (sampled == level_q) begin
                    count_d  = '0;
                    glitch_d = 1'b1;
                    state_d  = ST_STABLE;
                end else if (count_q == COUNT_LAST) begin
                    level_d = sampled;
                    count_d = '0;
                    state_d = ST_STABLE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                count_d = '0;
                state_d = ST_STABLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_high) begin
        if (reset_high) begin
            state_q  <= ST_STABLE;
            count_q  <= '0;
            level_q  <= RESET_LEVEL;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            level_q  <= level_d;
            glitch_q <= glitch_d;
        end
    end

    assign level    = level_q;
    assign settling = (state_q == ST_SETTLING);
    assign glitch   = glitch_q;

endmodule
